img_stream_src: RTL
===================

IMG_STREAM_SRC -- requirements
Module: img_stream_src

Interface
REQ-001 Parameter: IMG_W, 640, active pixels per line.
REQ-002 Parameter: IMG_H, 480, active lines per frame.
REQ-003 Parameter: DW, 16, pixel data width.
REQ-004 Port: clk  input  1  system clock; all logic on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: vsync  input  1  frame sync from capture side; rising edge marks frame start.
REQ-007 Port: href  input  1  line-active qualifier from capture side.
REQ-008 Port: pix_vld  input  1  one pixel present on pix_data this cycle; honoured only while href=1.
REQ-009 Port: pix_data  input  DW  pixel value.
REQ-010 Port: dout_sop  output  1  first pixel of frame, coincident with dout_vld.
REQ-011 Port: dout_eop  output  1  last pixel of frame, coincident with dout_vld.
REQ-012 Port: dout_vld  output  1  dout carries a pixel.
REQ-013 Port: dout  output  DW  pixel data.
REQ-014 Port: frame_err  output  1  one-cycle pulse on geometry violation.

Function
REQ-015 SHALL register vsync and href once internally; edges are detected on the registered copies against their previous values.
REQ-016 SHALL implement states IDLE, WAIT_PIX, ACTIVE, DROP; IDLE after reset.
REQ-017 IDLE -> WAIT_PIX on vsync rising edge; pixels in IDLE are discarded.
REQ-018 WAIT_PIX -> ACTIVE on first accepted pixel (href=1, pix_vld=1); that pixel is emitted with dout_sop=1.
REQ-019 Accepted pixel SHALL appear on dout/dout_vld exactly 1 cycle after pix_vld sampled; dout holds its last value when dout_vld=0.
REQ-020 Column counter (clog2(IMG_W) bits) SHALL increment per accepted pixel, wrap IMG_W-1 -> 0 and then increment row counter (clog2(IMG_H) bits).
REQ-021 Pixel at col=IMG_W-1, row=IMG_H-1 SHALL be emitted with dout_eop=1; state -> IDLE, counters cleared same cycle.
REQ-022 Single-pixel frame (IMG_W=IMG_H=1) SHALL emit dout_sop=dout_eop=1 on one beat.
REQ-023 Pixels arriving after eop and before next vsync rising edge SHALL be discarded with no error.
REQ-024 vsync rising edge in IDLE, WAIT_PIX or DROP SHALL restart at WAIT_PIX with counters cleared.
REQ-025 Simultaneous vsync rising edge and accepted pixel: vsync edge wins; pixel discarded, state WAIT_PIX.
REQ-026 dout_sop/dout_eop SHALL never assert without dout_vld; at most one sop and one eop per frame.

Reset
REQ-027 rst=1 SHALL force state IDLE, counters 0, dout_sop=dout_eop=dout_vld=frame_err=0, dout=0, edge-detect registers 0, on the next clk edge.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no eop; after release first output is a sop following a new vsync rising edge.

Configuration
REQ-029 Macro IMG_STREAM_SRC_CHK_EN SHALL compile in geometry checking.
REQ-030 With macro defined: href falling edge in ACTIVE with col!=0 (short line), or vsync rising edge in ACTIVE (short frame), SHALL pulse frame_err for 1 cycle; short line -> DROP (discard until vsync rising edge), short frame -> WAIT_PIX with counters cleared.
REQ-031 Without macro: frame_err tied 0, DROP state absent, short lines ignored (counting continues by pixels), vsync rising edge in ACTIVE restarts at WAIT_PIX silently.

Verification (IMG_W=4, IMG_H=2, DW=16)
REQ-032 Reset, vsync pulse, 2 lines of 4 pixels 0x0001..0x0008 -> 8 dout_vld beats, each 1 cycle after input, sop on 0x0001, eop on 0x0008, frame_err=0.
REQ-033 Pixels with pix_vld=1, href=0 inside frame, and pixels before any vsync -> no dout_vld.
REQ-034 CHK_EN: line 1 has 3 pixels then href falls -> frame_err pulse 1 cycle, no further dout_vld until next vsync; next good frame outputs normally.
REQ-035 vsync rising edge after 5 pixels -> no eop; CHK_EN frame_err=1, else 0; following 8 pixels produce a new sop..eop frame.
REQ-036 rst=1 for 1 cycle after 3 pixels -> all outputs 0 next cycle; pixels before next vsync produce no output.
REQ-037 Pixel gaps (pix_vld toggling 1/0) within lines -> same 8-beat sequence, output spacing mirrors input.

Source files
------------

// File: rtl/img_stream_src.sv
// Camera-style capture adapter: turns vsync/href/pix_vld into a framed pixel stream with sop/eop.
// Define IMG_STREAM_SRC_CHK_EN to compile in short-line / short-frame geometry checking (frame_err, DROP state).
module img_stream_src #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic          pix_vld,
  input  logic [DW-1:0] pix_data,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic          dout_vld,
  output logic [DW-1:0] dout,
  output logic          frame_err
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PIX,
    ACTIVE
`ifdef IMG_STREAM_SRC_CHK_EN
    , DROP
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            vld_q, vld_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic            vsync_q, vsync_prev_q;
  logic            vs_rise;
  logic            accept;
  logic            last_pix;
  logic            drop_line;
  logic            emit;

  // Edges are taken on the registered copies so the async capture side is sampled once.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      vsync_prev_q <= vsync_q;
    end
  end

  assign vs_rise  = vsync_q & ~vsync_prev_q;
  assign accept   = href & pix_vld;
  assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);

`ifdef IMG_STREAM_SRC_CHK_EN
  logic href_q, href_prev_q;
  logic href_fall;
  logic err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      href_q      <= href;
      href_prev_q <= href_q;
      err_q       <= err_d;
    end
  end

  assign href_fall = ~href_q & href_prev_q;
  // A line that ends with a partial column count means the sensor and our geometry disagree.
  assign drop_line = (state_q == ACTIVE) && href_fall && (col_q != '0);
  assign err_d     = drop_line | ((state_q == ACTIVE) && vs_rise);
  assign frame_err = err_q;
`else
  assign drop_line = 1'b0;
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (vs_rise) state_d = WAIT_PIX;
      end
      WAIT_PIX: begin
        if (vs_rise)     state_d = WAIT_PIX;
        else if (accept) state_d = last_pix ? IDLE : ACTIVE;
      end
      ACTIVE: begin
        if (vs_rise)                  state_d = WAIT_PIX;
`ifdef IMG_STREAM_SRC_CHK_EN
        else if (drop_line)           state_d = DROP;
`endif
        else if (accept && last_pix)  state_d = IDLE;
      end
`ifdef IMG_STREAM_SRC_CHK_EN
      DROP: begin
        if (vs_rise) state_d = WAIT_PIX;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // vsync edge has priority over a coincident pixel.
  assign emit = !vs_rise && accept &&
                ((state_q == WAIT_PIX) || ((state_q == ACTIVE) && !drop_line));

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    dout_d = dout_q;
    vld_d  = 1'b0;
    sop_d  = 1'b0;
    eop_d  = 1'b0;
    if (vs_rise) begin
      col_d = '0;
      row_d = '0;
    end else if (emit) begin
      vld_d  = 1'b1;
      dout_d = pix_data;
      sop_d  = (state_q == WAIT_PIX);
      eop_d  = last_pix;
      if (last_pix) begin
        col_d = '0;
        row_d = '0;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      sop_q  <= sop_d;
      eop_q  <= eop_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign dout_sop = sop_q;
  assign dout_eop = eop_q;

endmodule
